// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter for four data-side and four instruction-side processor ports,
// four snoop ports and one memory snoop port. Grants are registered with 1-cycle latency.
// There is no preemption: the owner holds the bus until it drops its request.
// After the owner drops, the bus idles for one cycle (RELEASE) before the next arbitration.
module com_bus_arbiter #(
   parameter int MAX_HOLD = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] Com_Bus_Req_proc,
   input  logic [3:0] Com_Bus_Req_snoop,
   input  logic       Mem_snoop_req,
   output logic [7:0] Com_Bus_Gnt_proc,
   output logic [3:0] Com_Bus_Gnt_snoop,
   output logic       Mem_snoop_gnt,
   output logic       Bus_busy,
   output logic [3:0] Owner_id,
   output logic       Hold_timeout
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_OWN     = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam int            CW        = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   localparam logic [3:0] OWNER_MEM  = 4'd12;
   localparam logic [3:0] OWNER_NONE = 4'd15;

   // Registered state
   logic [1:0]    state_q,     state_nxt;
   logic [7:0]    gnt_proc_q,  gnt_proc_nxt;
   logic [3:0]    gnt_snoop_q, gnt_snoop_nxt;
   logic          gnt_mem_q,   gnt_mem_nxt;
   logic          busy_q,      busy_nxt;
   logic [3:0]    owner_q,     owner_nxt;
   logic          tmo_q,       tmo_nxt;
   logic [CW-1:0] cnt_q,       cnt_nxt;
   logic [2:0]    ptr_q,       ptr_nxt;

   // Arbitration candidates
   logic          snoop_hit;
   logic [1:0]    snoop_idx;
   logic          proc_hit;
   logic [2:0]    proc_idx;
   logic          owner_req;

   // Lowest-index snoop request wins; scanning downward leaves the lowest hit last.
   always_comb begin
      snoop_hit = 1'b0;
      snoop_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (Com_Bus_Req_snoop[i]) begin
            snoop_hit = 1'b1;
            snoop_idx = 2'(i);
         end
      end
   end

   // Round-robin search starting at ptr+1; offset 8 wraps back to the pointer itself,
   // which is therefore the last candidate. Scanning downward keeps the nearest hit.
   always_comb begin
      proc_hit = 1'b0;
      proc_idx = 3'd0;
      for (int i = 8; i >= 1; i--) begin
         if (Com_Bus_Req_proc[3'(ptr_q + 3'(i))]) begin
            proc_hit = 1'b1;
            proc_idx = 3'(ptr_q + 3'(i));
         end
      end
   end

   // Select the current owner's request line from its encoded id.
   always_comb begin
      owner_req = 1'b0;
      if (owner_q < 4'd8) begin
         owner_req = Com_Bus_Req_proc[owner_q[2:0]];
      end else if (owner_q < 4'd12) begin
         owner_req = Com_Bus_Req_snoop[owner_q[1:0]];
      end else if (owner_q == OWNER_MEM) begin
         owner_req = Mem_snoop_req;
      end
   end

   // Next-state and next-output computation for the IDLE/OWN/RELEASE sequence.
   always_comb begin
      state_nxt     = state_q;
      gnt_proc_nxt  = gnt_proc_q;
      gnt_snoop_nxt = gnt_snoop_q;
      gnt_mem_nxt   = gnt_mem_q;
      busy_nxt      = busy_q;
      owner_nxt     = owner_q;
      tmo_nxt       = tmo_q;
      cnt_nxt       = cnt_q;
      ptr_nxt       = ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (snoop_hit) begin
               gnt_snoop_nxt = 4'b0001 << snoop_idx;
               owner_nxt     = 4'd8 + {2'b00, snoop_idx};
            end else if (Mem_snoop_req) begin
               gnt_mem_nxt   = 1'b1;
               owner_nxt     = OWNER_MEM;
            end else if (proc_hit) begin
               gnt_proc_nxt  = 8'b0000_0001 << proc_idx;
               owner_nxt     = {1'b0, proc_idx};
               ptr_nxt       = proc_idx;
            end
            if (snoop_hit || Mem_snoop_req || proc_hit) begin
               state_nxt = ST_OWN;
               busy_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end

         ST_OWN: begin
            if (owner_req) begin
               // Owner keeps the bus; count the held cycle and flag (without revoking)
               // once MAX_HOLD full cycles have elapsed.
               if (cnt_q != HOLD_MAX) begin
                  cnt_nxt = cnt_q + CW'(1);
               end
               if (cnt_q >= HOLD_LAST) begin
                  tmo_nxt = 1'b1;
               end
            end else begin
               gnt_proc_nxt  = 8'd0;
               gnt_snoop_nxt = 4'd0;
               gnt_mem_nxt   = 1'b0;
               owner_nxt     = OWNER_NONE;
               state_nxt     = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end

         default: begin
            state_nxt     = ST_IDLE;
            gnt_proc_nxt  = 8'd0;
            gnt_snoop_nxt = 4'd0;
            gnt_mem_nxt   = 1'b0;
            busy_nxt      = 1'b0;
            owner_nxt     = OWNER_NONE;
         end
      endcase
   end

   // State register; reset clears grants immediately and parks the pointer at 7
   // so the first processor grant after reset starts searching from index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_proc_q  <= 8'd0;
         gnt_snoop_q <= 4'd0;
         gnt_mem_q   <= 1'b0;
         busy_q      <= 1'b0;
         owner_q     <= OWNER_NONE;
         tmo_q       <= 1'b0;
         cnt_q       <= '0;
         ptr_q       <= 3'd7;
      end else begin
         state_q     <= state_nxt;
         gnt_proc_q  <= gnt_proc_nxt;
         gnt_snoop_q <= gnt_snoop_nxt;
         gnt_mem_q   <= gnt_mem_nxt;
         busy_q      <= busy_nxt;
         owner_q     <= owner_nxt;
         tmo_q       <= tmo_nxt;
         cnt_q       <= cnt_nxt;
         ptr_q       <= ptr_nxt;
      end
   end

   assign Com_Bus_Gnt_proc  = gnt_proc_q;
   assign Com_Bus_Gnt_snoop = gnt_snoop_q;
   assign Mem_snoop_gnt     = gnt_mem_q;
   assign Bus_busy          = busy_q;
   assign Owner_id          = owner_q;
   assign Hold_timeout      = tmo_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of owner, release gap,
// held-cycle count, round-robin position and sticky timeout.
module tb_com_bus_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_proc  = 8'd0;
   logic [3:0] req_snoop = 4'd0;
   logic       mem_req   = 1'b0;
   logic [7:0] gnt_proc;
   logic [3:0] gnt_snoop;
   logic       mem_gnt;
   logic       busy;
   logic [3:0] owner_id;
   logic       hold_tmo;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: owner code (-1 none, 0-7 proc, 8-11 snoop, 12 memory)
   int m_owner = -1;
   bit m_gap   = 1'b0;
   int m_held  = 0;
   int m_last  = 7;
   bit m_tmo   = 1'b0;

   com_bus_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk              (clk),
      .rst              (rst),
      .Com_Bus_Req_proc (req_proc),
      .Com_Bus_Req_snoop(req_snoop),
      .Mem_snoop_req    (mem_req),
      .Com_Bus_Gnt_proc (gnt_proc),
      .Com_Bus_Gnt_snoop(gnt_snoop),
      .Mem_snoop_gnt    (mem_gnt),
      .Bus_busy         (busy),
      .Owner_id         (owner_id),
      .Hold_timeout     (hold_tmo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit req_of(input int who);
      if (who < 8)  return req_proc[who];
      if (who < 12) return req_snoop[who - 8];
      return mem_req;
   endfunction

   function automatic void m_reset();
      m_owner = -1;
      m_gap   = 1'b0;
      m_held  = 0;
      m_last  = 7;
      m_tmo   = 1'b0;
   endfunction

   // One rising edge of the reference behaviour.
   function automatic void m_edge();
      if (rst) begin
         m_reset();
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (m_owner >= 0) begin
         if (req_of(m_owner)) begin
            m_held++;
            if (m_held >= MAXH) m_tmo = 1'b1;
         end else begin
            m_owner = -1;
            m_gap   = 1'b1;
         end
      end else begin
         int pick = -1;
         for (int s = 0; s < 4 && pick < 0; s++)
            if (req_snoop[s]) pick = 8 + s;
         if (pick < 0 && mem_req) pick = 12;
         for (int k = 1; k <= 8 && pick < 0; k++)
            if (req_proc[(m_last + k) % 8]) begin
               pick   = (m_last + k) % 8;
               m_last = pick;
            end
         if (pick >= 0) begin
            m_owner = pick;
            m_held  = 0;
         end
      end
   endfunction

   task automatic compare_all();
      chk("gnt_proc",  gnt_proc,  (m_owner >= 0 && m_owner < 8) ? 32'(1 << m_owner) : 0);
      chk("gnt_snoop", gnt_snoop, (m_owner >= 8 && m_owner < 12) ? 32'(1 << (m_owner - 8)) : 0);
      chk("mem_gnt",   mem_gnt,   m_owner == 12);
      chk("busy",      busy,      (m_owner >= 0) || m_gap);
      chk("owner_id",  owner_id,  (m_owner < 0) ? 15 : m_owner);
      chk("hold_tmo",  hold_tmo,  m_tmo);
      chk("one_hot",   $countones({gnt_proc, gnt_snoop, mem_gnt}) <= 1, 1);
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      compare_all();
   endtask

   // Asynchronous reset raised between edges; outputs must clear before any clock.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      m_reset();
      compare_all();
      chk("rst_async_gnt", {gnt_proc, gnt_snoop, mem_gnt}, 0);
      chk("rst_async_own", owner_id, 15);
      step();
      rst = 1'b0;
   endtask

   initial begin
      int last_own;
      int gap;
      int order[$];
      int gaps[$];

      // Reset state
      @(negedge clk);
      m_reset();
      compare_all();
      chk("reset_busy", busy, 0);
      chk("reset_own", owner_id, 15);
      rst = 1'b0;

      // Single request held 3 cycles
      req_proc = 8'h01;
      step();
      chk("single_gnt", gnt_proc, 8'h01);
      chk("single_own", owner_id, 0);
      step();
      step();
      req_proc = 8'h00;
      step();
      chk("single_drop_gnt", gnt_proc, 0);
      chk("single_drop_busy", busy, 1);
      step();
      chk("single_busy_low", busy, 0);

      // Round-robin with all 8 requesting, owners drop after 2 owned cycles
      do_reset();
      last_own = -1;
      gap = 0;
      for (int c = 0; c < 48; c++) begin
         req_proc = 8'hFF;
         if (m_owner >= 0 && m_owner < 8 && m_held >= 2) req_proc[m_owner] = 1'b0;
         step();
         if (gnt_proc == 0) gap++;
         else if (owner_id != last_own) begin
            order.push_back(int'(owner_id));
            if (order.size() > 1) gaps.push_back(gap);
            gap = 0;
            last_own = owner_id;
         end
         if (gnt_proc != 0) last_own = owner_id;
      end
      req_proc = 8'h00;
      chk("rr_count_ge9", order.size() >= 9, 1);
      for (int i = 0; i < 9 && i < order.size(); i++)
         chk("rr_order", order[i], i % 8);
      for (int i = 0; i < 8 && i < gaps.size(); i++)
         chk("rr_gap", gaps[i], 2);
      step();
      step();
      step();

      // Priority: snoop[2], then memory, then proc[0]
      do_reset();
      req_snoop = 4'h4;
      mem_req   = 1'b1;
      req_proc  = 8'h01;
      step();
      chk("prio_snoop", owner_id, 10);
      step();
      req_snoop = 4'h0;
      step();
      step();
      step();
      chk("prio_mem", owner_id, 12);
      mem_req = 1'b0;
      step();
      step();
      step();
      chk("prio_proc", owner_id, 0);
      req_proc = 8'h00;
      step();
      step();

      // Hold timeout with proc[3] held 10 cycles
      do_reset();
      req_proc = 8'h08;
      step();
      chk("tmo_gnt", gnt_proc, 8'h08);
      for (int i = 1; i < 10; i++) begin
         step();
         chk("tmo_edge", hold_tmo, i >= MAXH);
         chk("tmo_gnt_kept", gnt_proc, 8'h08);
      end
      req_proc = 8'h00;
      step();
      step();
      step();
      chk("tmo_sticky", hold_tmo, 1);

      // Reset mid-grant on proc[5], then all request: first grant to proc[0]
      do_reset();
      req_proc = 8'h20;
      step();
      step();
      chk("mid_gnt", gnt_proc, 8'h20);
      do_reset();
      chk("mid_gnt_cleared", gnt_proc, 0);
      req_proc = 8'hFF;
      step();
      chk("mid_first", owner_id, 0);
      req_proc = 8'h00;
      step();
      step();

      // Randomized traffic with short pulses between edges and occasional resets
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         req_proc  = 8'($urandom & $urandom);
         req_snoop = 4'($urandom & $urandom & $urandom);
         mem_req   = ($urandom_range(0, 9) == 0);
         if (m_owner >= 0) begin
            bit keep = ($urandom_range(0, 99) < 85);
            if (m_owner < 8)       req_proc[m_owner]      = keep;
            else if (m_owner < 12) req_snoop[m_owner - 8] = keep;
            else                   mem_req                = keep;
         end
         if ($urandom_range(0, 7) == 0) begin
            int k = $urandom_range(0, 7);
            if (!req_proc[k]) begin
               #1 req_proc[k] = 1'b1;
               #1 req_proc[k] = 1'b0;
            end
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/com_bus_arbiter.md
COM_BUS_ARBITER -- requirements
Module: com_bus_arbiter

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 1023, range >= 1: maximum owned cycles before a hold timeout is flagged.
REQ-002 SHALL provide port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide Com_Bus_Req_proc, input, 8 bits: processor-side requests; bits 0-3 are DL P1-P4, bits 4-7 are IL P1-P4.
REQ-005 SHALL provide Com_Bus_Req_snoop, input, 4 bits: snoop-side requests from DL P1-P4.
REQ-006 SHALL provide Mem_snoop_req, input, 1 bit: memory-side snoop request.
REQ-007 SHALL provide Com_Bus_Gnt_proc, output, 8 bits: processor grants, one-hot or zero.
REQ-008 SHALL provide Com_Bus_Gnt_snoop, output, 4 bits: snoop grants, one-hot or zero.
REQ-009 SHALL provide Mem_snoop_gnt, output, 1 bit: memory snoop grant.
REQ-010 SHALL provide Bus_busy, output, 1 bit: high in OWN and RELEASE states.
REQ-011 SHALL provide Owner_id, output, 4 bits: 0-7 proc index, 8-11 snoop index+8, 12 memory, 15 no owner.
REQ-012 SHALL provide Hold_timeout, output, 1 bit: sticky hold-violation flag.

Function
REQ-013 SHALL implement states IDLE, OWN, RELEASE; all outputs registered.
REQ-014 SHALL, across all 13 grant outputs combined, keep at most one grant bit high in any cycle.
REQ-015 SHALL, in IDLE, sample all requests at each edge; if any are high, it SHALL issue exactly one grant at that edge (1-cycle latency) and enter OWN; otherwise it SHALL stay in IDLE.
REQ-016 SHALL apply priority as follows: snoop requests first, lowest index wins; then Mem_snoop_req; then processor requests by round-robin.
REQ-017 SHALL run processor round-robin from pointer+1 mod 8, wrapping 7->0; the pointer SHALL load the granted index only on a processor grant.
REQ-018 SHALL, in OWN, hold the grant while the owner's request is sampled high; there SHALL be no preemption, and other requests SHALL wait.
REQ-019 SHALL, at the edge where the owner's request is sampled low, clear all grants, set Owner_id=15 and enter RELEASE.
REQ-020 SHALL stay in RELEASE for exactly one cycle with no grant, then go to IDLE unconditionally; if the owner drops at edge k, the earliest next grant SHALL follow edge k+2.
REQ-021 SHALL zero the hold counter on each grant and increment it, saturating, on each OWN edge with the owner's request high.
REQ-022 SHALL set Hold_timeout at the edge where the owner has held MAX_HOLD full cycles and its request is still high; the grant SHALL NOT be revoked.
REQ-023 SHALL keep Hold_timeout set until rst.
REQ-024 SHALL ignore request pulses that begin and end between edges.
REQ-025 SHALL ignore requests from non-owners while in OWN or RELEASE; they SHALL NOT be latched.

Reset
REQ-026 SHALL, on rst high and without waiting for a clock edge, immediately clear all grants and apply these values: Bus_busy=0, Hold_timeout=0, Owner_id=15, state=IDLE, hold counter=0, round-robin pointer=7.
REQ-027 SHALL, when rst is asserted mid-ownership, drop the grant immediately; after release, the first processor grant SHALL go to the lowest requesting index starting from 0.

Verification
REQ-028 SHALL cover reset: assert rst -> all grants 0, Bus_busy 0, Owner_id 15, Hold_timeout 0.
REQ-029 SHALL cover a single request: Com_Bus_Req_proc=0x01 held 3 cycles -> Com_Bus_Gnt_proc=0x01 after the first edge, Owner_id 0; request drops -> grant 0 at the next edge, Bus_busy low one cycle later.
REQ-030 SHALL cover round-robin: all 8 processor requests held, each owner releasing after 2 owned cycles -> grant order 0,1,2,3,4,5,6,7,0 with a 2-cycle gap between grants.
REQ-031 SHALL cover priority: Com_Bus_Req_snoop=0x4, Mem_snoop_req=1 and Com_Bus_Req_proc=0x01 raised together -> grant order snoop[2] (Owner_id 10), then memory (12), then proc[0] (0).
REQ-032 SHALL cover timeout: MAX_HOLD=4, proc[3] request held 10 cycles -> Hold_timeout rises at the 4th edge after the grant, the grant persists, and the flag stays high after release.
REQ-033 SHALL cover reset mid-grant: rst asserted during a proc[5] grant -> grant 0 with no clock; after release with Com_Bus_Req_proc=0xFF -> the first grant goes to proc[0].
